// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and frame-length helper.
// Reused by the transmit framer and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Total bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick marks the last clk cycle of each CLKS_PER_BIT period.
// Latency: tick is decoded from the count register, no extra delay.
// Backpressure: none; clear restarts the period from zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Latency: tx falls the cycle after accept; frame spans F*CLKS_PER_BIT cycles.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored while a frame is in flight.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_framer: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 par, par_n;
  logic                 stop_cnt, stop_n;
  logic                 tx_n;
  logic                 tick;
  logic                 bit_clear;
  logic                 stop_last;

  assign tx_ready  = (state == IDLE) && !reset;
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign bit_clear = (state_n != state);
  // Decoded purely from registers: high exactly in the final cycle of the last stop bit.
  assign done      = (state == STOP) && stop_last && tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(bit_clear),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    par_n   = par;
    stop_n  = stop_cnt;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_n = tx_data;
          par_n   = (^tx_data) ^ (PARITY_ODD != 0);
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          idx_n   = idx + 1'b1;
          if (idx == IW'(DATA_BITS - 1)) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
            stop_n  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_last) state_n = IDLE;
          else           stop_n  = stop_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered, so drive the value belonging to the next state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      idx      <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      par      <= par_n;
      stop_cnt <= stop_n;
      tx       <= tx_n;
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: six parameter variants at CLKS_PER_BIT=4,
// table vectors, random words, back-to-back, mid-frame disturbance and reset.
module tb_uart_tx_framer;

  localparam int C  = 4;
  localparam int NI = 6;
  localparam int DB [NI] = '{8, 7, 7, 8, 9, 5};
  localparam int PE [NI] = '{0, 1, 1, 0, 0, 0};
  localparam int PO [NI] = '{0, 0, 1, 0, 0, 0};
  localparam int SB [NI] = '{1, 1, 1, 2, 1, 1};

  typedef struct {
    int         inst;
    logic [8:0] word;
    int         len;
    int         par;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [8:0]    data [NI];
  logic [NI-1:0] valid;
  logic [NI-1:0] tx, busy, done, rdy;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_done = 0;
  logic expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_framer #(
      .DATA_BITS   (DB[g]),
      .CLKS_PER_BIT(C),
      .STOP_BITS   (SB[g]),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g])
    ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_data (data[g][DB[g]-1:0]),
      .tx_valid(valid[g]),
      .tx_ready(rdy[g]),
      .tx      (tx[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference frame as a list of line levels, one entry per bit period.
  task automatic build(input int i, input logic [8:0] w);
    int ones;
    ones = 0;
    expq.delete();
    expq.push_back(1'b0);
    for (int j = 0; j < DB[i]; j++) begin
      expq.push_back(w[j]);
      ones += int'(w[j]);
    end
    if (PE[i] != 0) expq.push_back(1'((ones % 2) ^ PO[i]));
    for (int s = 0; s < SB[i]; s++) expq.push_back(1'b1);
  endtask

  // Entered at the negedge of the accept cycle with data/valid already driven;
  // returns at the negedge of the idle cycle following the frame.
  task automatic frame(input int i, input logic [8:0] w, input bit hold,
                       input logic [8:0] next_w, input bit disturb,
                       output int done_k, output logic [15:0] seen);
    int nb;
    build(i, w);
    nb = expq.size();
    done_k = -1;
    seen = '0;
    chk($sformatf("u%0d ready_at_accept", i), int'(rdy[i]), 1);
    for (int k = 1; k <= nb * C; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) data[i] = next_w;
        else      valid[i] = 1'b0;
      end
      if (disturb && k == 2 * C + 3) begin
        data[i]  = ~w;
        valid[i] = 1'b1;
      end
      if (disturb && k == 2 * C + 4) valid[i] = 1'b0;
      chk($sformatf("u%0d tx k=%0d", i, k), int'(tx[i]), int'(expq[(k-1)/C]));
      chk($sformatf("u%0d busy k=%0d", i, k), int'(busy[i]), 1);
      chk($sformatf("u%0d ready k=%0d", i, k), int'(rdy[i]), 0);
      chk($sformatf("u%0d done k=%0d", i, k), int'(done[i]), (k == nb * C) ? 1 : 0);
      if (done[i] && done_k < 0) begin
        done_k    = k;
        last_done = cyc;
      end
      if ((k - 1) % C == C / 2) seen[(k-1)/C] = tx[i];
    end
    @(negedge clk);
    chk($sformatf("u%0d idle tx", i), int'(tx[i]), 1);
    chk($sformatf("u%0d idle busy", i), int'(busy[i]), 0);
    chk($sformatf("u%0d idle done", i), int'(done[i]), 0);
    chk($sformatf("u%0d idle ready", i), int'(rdy[i]), 1);
  endtask

  initial begin
    vec_t        tbl [5];
    int          dk, d1, i;
    logic [8:0]  w;
    logic [15:0] seen;

    tbl[0] = '{0, 9'h0A5, 10, -1};
    tbl[1] = '{1, 9'h013, 10,  1};
    tbl[2] = '{2, 9'h013, 10,  0};
    tbl[3] = '{4, 9'h1FF, 11, -1};
    tbl[4] = '{5, 9'h015,  7, -1};

    valid = '0;
    for (int n = 0; n < NI; n++) data[n] = '0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      chk($sformatf("u%0d reset tx", n), int'(tx[n]), 1);
      chk($sformatf("u%0d reset busy", n), int'(busy[n]), 0);
      chk($sformatf("u%0d reset done", n), int'(done[n]), 0);
      chk($sformatf("u%0d reset ready", n), int'(rdy[n]), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int n = 0; n < NI; n++) chk($sformatf("u%0d ready after reset", n), int'(rdy[n]), 1);

    // Table vectors: frame length via done timing, parity bit sampled mid-period.
    for (int t = 0; t < 5; t++) begin
      i = tbl[t].inst;
      data[i]  = tbl[t].word;
      valid[i] = 1'b1;
      frame(i, tbl[t].word, 1'b0, 9'h0, 1'b0, dk, seen);
      chk($sformatf("vec%0d frame cycles", t), dk, tbl[t].len * C);
      if (tbl[t].par >= 0) chk($sformatf("vec%0d parity", t), int'(seen[DB[i]+1]), tbl[t].par);
    end

    // Back-to-back with tx_valid held high on the 2-stop-bit variant.
    data[3]  = 9'h000;
    valid[3] = 1'b1;
    frame(3, 9'h000, 1'b1, 9'h0FF, 1'b0, dk, seen);
    d1 = last_done;
    frame(3, 9'h0FF, 1'b0, 9'h0, 1'b0, dk, seen);
    chk("b2b done spacing", last_done - d1, 45);

    // Mid-frame data change and tx_valid pulse must not disturb the frame.
    data[0]  = 9'h0C3;
    valid[0] = 1'b1;
    frame(0, 9'h0C3, 1'b0, 9'h0, 1'b1, dk, seen);
    chk("disturb frame cycles", dk, 40);

    // Reset during the third data bit abandons the frame without done.
    w        = 9'h05A;
    data[0]  = w;
    valid[0] = 1'b1;
    for (int k = 1; k <= 3 * C + 1; k++) begin
      @(negedge clk);
      if (k == 1) valid[0] = 1'b0;
      chk($sformatf("rst pre done k=%0d", k), int'(done[0]), 0);
    end
    chk("rst in bit3 tx", int'(tx[0]), int'(w[2]));
    reset = 1'b1;
    @(negedge clk);
    chk("rst held tx", int'(tx[0]), 1);
    chk("rst held busy", int'(busy[0]), 0);
    chk("rst held done", int'(done[0]), 0);
    chk("rst held ready", int'(rdy[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst after tx", int'(tx[0]), 1);
    chk("rst after busy", int'(busy[0]), 0);
    chk("rst after done", int'(done[0]), 0);
    chk("rst after ready", int'(rdy[0]), 1);
    data[0]  = 9'h03C;
    valid[0] = 1'b1;
    frame(0, 9'h03C, 1'b0, 9'h0, 1'b0, dk, seen);

    // Random words across all variants against the reference frame model.
    for (int r = 0; r < 12; r++) begin
      i = $urandom_range(0, NI - 1);
      w = 9'($urandom);
      data[i]  = w;
      valid[i] = 1'b1;
      frame(i, w, 1'b0, 9'h0, 1'b0, dk, seen);
      chk($sformatf("rand%0d frame cycles", r), dk,
          (1 + DB[i] + PE[i] + SB[i]) * C);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
